// File: rtl/pattern_sequencer.sv
// pattern_sequencer: walks a list of (buffer, repeat) entries and streams
// bytes 0..field_last of each selected pattern buffer over valid/ready.
// The FSM is split into a state register, a next-state process and an
// output process that computes the next value of every registered output.
module pattern_sequencer #(
  parameter int BUFFER_WIDTH = 8,
  parameter int BUFFER_SIZE  = 32,
  parameter int NO_BUFS      = 8,
  parameter int SEQ_SIZE     = 32,
  localparam int FIELD_W     = $clog2(BUFFER_SIZE),
  localparam int BUF_W       = $clog2(NO_BUFS),
  localparam int SEQ_W       = $clog2(SEQ_SIZE),
  localparam int REP_W       = BUFFER_WIDTH - BUF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [SEQ_W-1:0]        seq_last,
  input  logic [FIELD_W-1:0]      field_last,
  output logic [SEQ_W-1:0]        seq_ptr,
  input  logic [BUFFER_WIDTH-1:0] seq_byte,
  output logic [BUF_W-1:0]        bufp,
  output logic [FIELD_W-1:0]      fieldp,
  input  logic [BUFFER_WIDTH-1:0] field_byte,
  output logic [BUFFER_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  state_t             adv_state_s;
  logic [SEQ_W-1:0]   seq_ptr_r, seq_ptr_s, adv_ptr_s;
  logic [BUF_W-1:0]   bufp_r, bufp_s;
  logic [FIELD_W-1:0] fieldp_r, fieldp_s;
  logic [REP_W-1:0]   rep_r, rep_s;
  logic               out_valid_r, out_valid_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;
  logic [REP_W-1:0]   entry_rep_s;
  logic [BUF_W-1:0]   entry_buf_s;
  logic               xfer_s;
  logic               pass_end_s;

  assign entry_rep_s = seq_byte[BUFFER_WIDTH-1:BUF_W];
  assign entry_buf_s = seq_byte[BUF_W-1:0];
  assign xfer_s      = out_valid_r & out_ready;
  // Last byte of the last repeat of this entry is being accepted.
  assign pass_end_s  = xfer_s && (fieldp_r == field_last) && (rep_r <= REP_W'(1));

  // Where playback goes once the current entry is finished or skipped.
  always_comb begin
    adv_ptr_s   = seq_ptr_r;
    adv_state_s = ST_DONE;
    if (seq_ptr_r < seq_last) begin
      adv_ptr_s   = seq_ptr_r + SEQ_W'(1);
      adv_state_s = ST_FETCH;
    end else if (loop_en) begin
      adv_ptr_s   = {SEQ_W{1'b0}};
      adv_state_s = ST_FETCH;
    end else begin
      adv_ptr_s   = seq_ptr_r;
      adv_state_s = ST_DONE;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; stop overrides everything and returns to IDLE.
  always_comb begin
    state_s = state_r;
    if (stop) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (entry_rep_s != {REP_W{1'b0}}) begin
            state_s = ST_STREAM;
          end else begin
            state_s = adv_state_s;
          end
        end
        ST_STREAM: begin
          if (pass_end_s) begin
            state_s = adv_state_s;
          end else begin
            state_s = ST_STREAM;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Next values of the pointers, repeat counter and handshake outputs.
  always_comb begin
    seq_ptr_s   = seq_ptr_r;
    bufp_s      = bufp_r;
    fieldp_s    = fieldp_r;
    rep_s       = rep_r;
    out_valid_s = out_valid_r;
    if (stop) begin
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid_s = 1'b0;
          if (start) begin
            seq_ptr_s = {SEQ_W{1'b0}};
          end else begin
            seq_ptr_s = seq_ptr_r;
          end
        end
        ST_FETCH: begin
          bufp_s   = entry_buf_s;
          rep_s    = entry_rep_s;
          fieldp_s = {FIELD_W{1'b0}};
          if (entry_rep_s != {REP_W{1'b0}}) begin
            out_valid_s = 1'b1;
          end else begin
            // Zero-repeat entry: skip straight to the next one.
            out_valid_s = 1'b0;
            seq_ptr_s   = adv_ptr_s;
          end
        end
        ST_STREAM: begin
          if (!xfer_s) begin
            fieldp_s = fieldp_r;
          end else if (fieldp_r != field_last) begin
            fieldp_s = fieldp_r + FIELD_W'(1);
          end else begin
            fieldp_s = {FIELD_W{1'b0}};
            if (rep_r > REP_W'(1)) begin
              rep_s = rep_r - REP_W'(1);
            end else begin
              out_valid_s = 1'b0;
              seq_ptr_s   = adv_ptr_s;
            end
          end
        end
        ST_DONE: begin
          out_valid_s = 1'b0;
        end
        default: begin
          out_valid_s = 1'b0;
        end
      endcase
    end
    done_s = (state_s == ST_DONE);
    busy_s = (state_s != ST_IDLE);
  end

  // Output and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_ptr_r   <= {SEQ_W{1'b0}};
      bufp_r      <= {BUF_W{1'b0}};
      fieldp_r    <= {FIELD_W{1'b0}};
      rep_r       <= {REP_W{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      seq_ptr_r   <= seq_ptr_s;
      bufp_r      <= bufp_s;
      fieldp_r    <= fieldp_s;
      rep_r       <= rep_s;
      out_valid_r <= out_valid_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
    end
  end

  assign seq_ptr   = seq_ptr_r;
  assign bufp      = bufp_r;
  assign fieldp    = fieldp_r;
  assign out_valid = out_valid_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign out_data  = field_byte;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer. The pattern bank is modelled so
// that the byte at (buffer b, field f) is {b, f}, which makes every expected
// stream easy to write down by hand.
module tb_pattern_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [4:0] seq_last;
  logic [4:0] field_last;
  logic [4:0] seq_ptr;
  logic [7:0] seq_byte;
  logic [2:0] bufp;
  logic [4:0] fieldp;
  logic [7:0] field_byte;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] seq_mem [32];
  logic [7:0] got [$];
  logic [7:0] exp [$];
  int checks;
  int errors;

  pattern_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .seq_last(seq_last), .field_last(field_last), .seq_ptr(seq_ptr),
    .seq_byte(seq_byte), .bufp(bufp), .fieldp(fieldp), .field_byte(field_byte),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  assign seq_byte   = seq_mem[seq_ptr];
  assign field_byte = {bufp, fieldp};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Index of first difference between got and exp, -2 on size mismatch, -1 if equal.
  function automatic int first_diff();
    if (got.size() != exp.size()) return -2;
    foreach (got[i]) if (got[i] !== exp[i]) return i;
    return -1;
  endfunction

  // Runs the stream until done or the cycle budget expires, recording accepted bytes.
  task automatic capture(input int max_cycles, input bit toggle, output int n_done,
                         output int cycles, output int bubbles, output int held_bad);
    bit prev_stall;
    logic [7:0] prev_data;
    logic [4:0] prev_field;
    got.delete();
    n_done = 0; cycles = 0; bubbles = 0; held_bad = 0; prev_stall = 1'b0;
    prev_data = 8'h00; prev_field = 5'd0;
    for (int c = 0; c < max_cycles; c++) begin
      out_ready = toggle ? ~c[0] : 1'b1;
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data || fieldp !== prev_field)) held_bad++;
      if (out_valid && out_ready) got.push_back(out_data);
      if (busy && !out_valid && !done) bubbles++;
      if (done) n_done++;
      cycles++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_field = fieldp;
      if (done) break;
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (seq_ptr !== 5'd0) begin errors++; $display("FAIL reset_seq_ptr: got %0d expected 0", seq_ptr); end
    checks++; if (bufp !== 3'd0) begin errors++; $display("FAIL reset_bufp: got %0d expected 0", bufp); end
    checks++; if (fieldp !== 5'd0) begin errors++; $display("FAIL reset_fieldp: got %0d expected 0", fieldp); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_entry();
    int nd, cy, bb, hb, d;
    seq_mem[0] = 8'h0A; seq_last = 5'd0; field_last = 5'd3;
    exp.delete();
    for (int f = 0; f < 4; f++) exp.push_back({3'd2, 5'(f)});
    kick();
    capture(40, 1'b0, nd, cy, bb, hb);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t1_stream: got %0d bytes expected %0d, diff at %0d", got.size(), exp.size(), d); end
    checks++; if (nd != 1) begin errors++; $display("FAIL t1_done: got %0d pulses expected 1", nd); end
    checks++; if (bb != 1) begin errors++; $display("FAIL t1_bubbles: got %0d expected 1", bb); end
    checks++; if (cy != 6) begin errors++; $display("FAIL t1_latency: got %0d cycles expected 6", cy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_two_entries();
    int nd, cy, bb, hb, d;
    seq_mem[0] = 8'h11; seq_mem[1] = 8'h1B; seq_last = 5'd1; field_last = 5'd1;
    exp.delete();
    for (int r = 0; r < 2; r++) for (int f = 0; f < 2; f++) exp.push_back({3'd1, 5'(f)});
    for (int r = 0; r < 3; r++) for (int f = 0; f < 2; f++) exp.push_back({3'd3, 5'(f)});
    kick();
    capture(60, 1'b0, nd, cy, bb, hb);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t2_stream: got %0d bytes expected %0d, diff at %0d", got.size(), exp.size(), d); end
    checks++; if (nd != 1) begin errors++; $display("FAIL t2_done: got %0d pulses expected 1", nd); end
    checks++; if (bb != 2) begin errors++; $display("FAIL t2_bubbles: got %0d expected 2", bb); end
    checks++; if (cy != 13) begin errors++; $display("FAIL t2_cycles: got %0d expected 13", cy); end
    step();
  endtask

  task automatic test_backpressure();
    int nd, cy, bb, hb, d;
    seq_mem[0] = 8'h11; seq_mem[1] = 8'h1B; seq_last = 5'd1; field_last = 5'd1;
    exp.delete();
    for (int r = 0; r < 2; r++) for (int f = 0; f < 2; f++) exp.push_back({3'd1, 5'(f)});
    for (int r = 0; r < 3; r++) for (int f = 0; f < 2; f++) exp.push_back({3'd3, 5'(f)});
    kick();
    capture(80, 1'b1, nd, cy, bb, hb);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t3_stream: got %0d bytes expected %0d, diff at %0d", got.size(), exp.size(), d); end
    checks++; if (hb != 0) begin errors++; $display("FAIL t3_hold: got %0d stall violations expected 0", hb); end
    checks++; if (nd != 1) begin errors++; $display("FAIL t3_done: got %0d pulses expected 1", nd); end
    step();
  endtask

  task automatic test_skip_entry();
    int nd, cy, bb, hb, d;
    seq_mem[0] = 8'h09; seq_mem[1] = 8'h05; seq_mem[2] = 8'h0B;
    seq_last = 5'd2; field_last = 5'd1;
    exp.delete();
    exp.push_back(8'h20); exp.push_back(8'h21); exp.push_back(8'h60); exp.push_back(8'h61);
    kick();
    capture(40, 1'b0, nd, cy, bb, hb);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t4_stream: got %0d bytes expected %0d, diff at %0d", got.size(), exp.size(), d); end
    checks++; if (bb != 3) begin errors++; $display("FAIL t4_bubbles: got %0d expected 3", bb); end
    checks++; if (cy != 8) begin errors++; $display("FAIL t4_cycles: got %0d expected 8", cy); end
    checks++; if (nd != 1) begin errors++; $display("FAIL t4_done: got %0d pulses expected 1", nd); end
    step();
  endtask

  task automatic test_field_last_zero();
    int nd, cy, bb, hb, d;
    seq_mem[0] = 8'h13; seq_mem[1] = 8'h0C; seq_last = 5'd1; field_last = 5'd0;
    exp.delete();
    exp.push_back(8'h60); exp.push_back(8'h60); exp.push_back(8'h80);
    kick();
    capture(30, 1'b0, nd, cy, bb, hb);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL fl0_stream: got %0d bytes expected %0d, diff at %0d", got.size(), exp.size(), d); end
    checks++; if (cy != 6) begin errors++; $display("FAIL fl0_cycles: got %0d expected 6", cy); end
    step();
  endtask

  task automatic test_loop_stop();
    int nd, cy, bb, hb, d;
    seq_mem[0] = 8'h0A; seq_last = 5'd0; field_last = 5'd3; loop_en = 1'b1;
    exp.delete();
    for (int r = 0; r < 4; r++) for (int f = 0; f < 4; f++) exp.push_back({3'd2, 5'(f)});
    kick();
    capture(20, 1'b0, nd, cy, bb, hb);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t5_stream: got %0d bytes expected %0d, diff at %0d", got.size(), exp.size(), d); end
    checks++; if (nd != 0) begin errors++; $display("FAIL t5_no_done: got %0d pulses expected 0", nd); end
    checks++; if (bb != 4) begin errors++; $display("FAIL t5_bubbles: got %0d expected 4", bb); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t5_streaming: got valid %b expected 1", out_valid); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_stop_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_stop_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t5_stop_done: got %b expected 0", done); end
    checks++; if (fieldp !== 5'd0) begin errors++; $display("FAIL t5_stop_fieldp: got %0d expected 0", fieldp); end
    checks++; if (bufp !== 3'd2) begin errors++; $display("FAIL t5_stop_bufp: got %0d expected 2", bufp); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t5_after_stop: got done %b busy %b expected 0 0", done, busy); end
  endtask

  task automatic test_start_while_busy();
    int nd, cy, bb, hb, d;
    seq_mem[0] = 8'h11; seq_mem[1] = 8'h1B; seq_last = 5'd1; field_last = 5'd1;
    exp.delete();
    for (int r = 0; r < 2; r++) for (int f = 0; f < 2; f++) exp.push_back({3'd1, 5'(f)});
    for (int r = 0; r < 3; r++) for (int f = 0; f < 2; f++) exp.push_back({3'd3, 5'(f)});
    kick();
    start = 1'b1;
    capture(60, 1'b0, nd, cy, bb, hb);
    start = 1'b0;
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t6_busy_start_stream: got %0d bytes expected %0d, diff at %0d", got.size(), exp.size(), d); end
    checks++; if (cy != 13) begin errors++; $display("FAIL t6_busy_start_cycles: got %0d expected 13", cy); end
    step();
  endtask

  task automatic test_reset_mid_stream();
    seq_mem[0] = 8'h11; seq_mem[1] = 8'h1B; seq_last = 5'd1; field_last = 5'd1;
    out_ready = 1'b1;
    kick();
    step();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t6_pre_reset_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL t6_reset_flags: got valid %b busy %b done %b expected 0 0 0", out_valid, busy, done);
    end
    checks++; if (seq_ptr !== 5'd0 || bufp !== 3'd0 || fieldp !== 5'd0) begin
      errors++; $display("FAIL t6_reset_ptrs: got seq_ptr %0d bufp %0d fieldp %0d expected 0 0 0", seq_ptr, bufp, fieldp);
    end
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_after_reset_busy: got %b expected 0", busy); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
    seq_last = 5'd0; field_last = 5'd0;
    for (int i = 0; i < 32; i++) seq_mem[i] = 8'h00;
    test_reset();
    test_single_entry();
    test_two_entries();
    test_backpressure();
    test_skip_entry();
    test_field_last_zero();
    test_loop_stop();
    test_start_while_busy();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
